spi_arbiter: RTL and testbench

- Shares the single byte-wide spi master between NUM_REQ requesters (e.g. controller pad, display, flash).
- Round-robin grant per burst; CS_n held low across a multi-byte burst.
- Sequences one byte at a time into the master (start/done handshake) and routes each MISO byte back to the granted requester.
- Enforces a CS-high gap between bursts.

---
 rtl/spi_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_spi_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one byte-wide SPI master between NUM_REQ requesters.
// Optional spi_done watchdog enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_arbiter #(
    parameter int unsigned NUM_REQ     = 2,
    parameter int unsigned CS_GAP      = 2,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   tx_data,
    input  logic [NUM_REQ-1:0]     tx_valid,
    input  logic [NUM_REQ-1:0]     tx_last,
    output logic [NUM_REQ-1:0]     tx_ready,
    output logic [NUM_REQ-1:0]     gnt,
    output logic [7:0]             rx_data,
    output logic [NUM_REQ-1:0]     rx_valid,
    output logic [7:0]             spi_mosi_data,
    output logic                   spi_start,
    output logic                   spi_cs_n,
    input  logic [7:0]             spi_miso_data,
    input  logic                   spi_done,
    output logic                   timeout
);

    localparam int unsigned PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned GAP_CYC = (CS_GAP == 0) ? 1 : CS_GAP;
    localparam int unsigned GW      = $clog2(GAP_CYC + 1);

    typedef enum logic [2:0] {IDLE, SETUP, LOAD, XFER, GAP} state_e;

    state_e               state_q, state_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [PW-1:0]        gidx_q, gidx_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic                 cs_n_q, cs_n_d;
    logic                 last_q, last_d;
    logic [GW-1:0]        gap_q, gap_d;
    logic [7:0]           rx_data_q, rx_data_d;
    logic [7:0]           mosi_q, mosi_d;
    logic [NUM_REQ-1:0]   tx_ready_q, tx_ready_d;
    logic [NUM_REQ-1:0]   rx_valid_q, rx_valid_d;
    logic                 start_q, start_d;
    logic                 timeout_q, timeout_d;

    logic [PW-1:0]        win_c;
    logic                 found_c;
    int unsigned          idx_c;
    logic [7:0]           tx_byte_c;
    logic                 tx_valid_c, tx_last_c, req_g_c;
    logic                 close_c;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int unsigned TO_CYC = (TIMEOUT_CYC == 0) ? 1 : TIMEOUT_CYC;
    localparam int unsigned TW     = $clog2(TO_CYC + 1);
    logic [TW-1:0]        to_cnt_q, to_cnt_d;
`else
    logic                 unused_timeout_cfg;
    assign unused_timeout_cfg = |TIMEOUT_CYC;
`endif

    // Round-robin search starting just after the last winner
    always_comb begin
        win_c   = ptr_q;
        found_c = 1'b0;
        idx_c   = 0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx_c = 32'(ptr_q) + i;
            if (idx_c >= NUM_REQ) idx_c = idx_c - NUM_REQ;
            if (!found_c && req[PW'(idx_c)]) begin
                found_c = 1'b1;
                win_c   = PW'(idx_c);
            end
        end
    end

    // Inputs of the currently granted requester
    always_comb begin
        tx_byte_c  = '0;
        tx_valid_c = 1'b0;
        tx_last_c  = 1'b0;
        req_g_c    = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gidx_q == PW'(i)) begin
                tx_byte_c  = tx_data[8*i +: 8];
                tx_valid_c = tx_valid[i];
                tx_last_c  = tx_last[i];
                req_g_c    = req[i];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gidx_d     = gidx_q;
        gnt_d      = gnt_q;
        cs_n_d     = cs_n_q;
        last_d     = last_q;
        gap_d      = gap_q;
        rx_data_d  = rx_data_q;
        mosi_d     = mosi_q;
        tx_ready_d = '0;
        rx_valid_d = '0;
        start_d    = 1'b0;
        timeout_d  = 1'b0;
        close_c    = 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
        to_cnt_d   = to_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (found_c) begin
                    gidx_d        = win_c;
                    ptr_d         = win_c;
                    gnt_d         = '0;
                    gnt_d[win_c]  = 1'b1;
                    cs_n_d        = 1'b0;
                    state_d       = SETUP;
                end
            end
            SETUP: state_d = LOAD;
            LOAD: begin
                if (tx_valid_c) begin
                    tx_ready_d[gidx_q] = 1'b1;
                    start_d            = 1'b1;
                    mosi_d             = tx_byte_c;
                    last_d             = tx_last_c;
                    state_d            = XFER;
`ifdef SPI_ARB_TIMEOUT_EN
                    to_cnt_d           = '0;
`endif
                end else if (!req_g_c) begin
                    close_c = 1'b1;
                end
            end
            XFER: begin
                if (spi_done) begin
                    rx_data_d          = spi_miso_data;
                    rx_valid_d[gidx_q] = 1'b1;
                    if (last_q || !req_g_c) close_c = 1'b1;
                    else                    state_d = LOAD;
                end
`ifdef SPI_ARB_TIMEOUT_EN
                else if (to_cnt_q == TW'(TO_CYC - 1)) begin
                    timeout_d = 1'b1;
                    close_c   = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
                end
`endif
            end
            GAP: begin
                if (gap_q == '0) state_d = IDLE;
                else             gap_d   = gap_q - GW'(1);
            end
            default: state_d = IDLE;
        endcase
        // End of burst: release CS and hold it high for the gap
        if (close_c) begin
            cs_n_d  = 1'b1;
            gnt_d   = '0;
            gap_d   = GW'(GAP_CYC - 1);
            state_d = GAP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= PW'(NUM_REQ - 1);
            gidx_q     <= '0;
            gnt_q      <= '0;
            cs_n_q     <= 1'b1;
            last_q     <= 1'b0;
            gap_q      <= '0;
            rx_data_q  <= '0;
            mosi_q     <= '0;
            tx_ready_q <= '0;
            rx_valid_q <= '0;
            start_q    <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gidx_q     <= gidx_d;
            gnt_q      <= gnt_d;
            cs_n_q     <= cs_n_d;
            last_q     <= last_d;
            gap_q      <= gap_d;
            rx_data_q  <= rx_data_d;
            mosi_q     <= mosi_d;
            tx_ready_q <= tx_ready_d;
            rx_valid_q <= rx_valid_d;
            start_q    <= start_d;
            timeout_q  <= timeout_d;
        end
    end

`ifdef SPI_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) to_cnt_q <= '0;
        else        to_cnt_q <= to_cnt_d;
    end
`endif

    assign tx_ready      = tx_ready_q;
    assign gnt           = gnt_q;
    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign spi_mosi_data = mosi_q;
    assign spi_start     = start_q;
    assign spi_cs_n      = cs_n_q;
    assign timeout       = timeout_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// Scoreboard bench for spi_arbiter: echo master model, per-requester byte feeders.
// Define SPI_ARB_TIMEOUT_EN to also exercise the spi_done watchdog.
module tb_spi_arbiter;

    localparam int unsigned NR     = 2;
    localparam int unsigned CS_GAP = 2;
    localparam int unsigned TO     = 8;
    localparam int unsigned DLY    = 16;

    logic              clk, rst_n;
    logic [NR-1:0]     req, tx_valid, tx_last, tx_ready, gnt, rx_valid;
    logic [8*NR-1:0]   tx_data;
    logic [7:0]        rx_data, spi_mosi_data, spi_miso_data;
    logic              spi_start, spi_cs_n, spi_done, timeout;

    spi_arbiter #(.NUM_REQ(NR), .CS_GAP(CS_GAP), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_last(tx_last), .tx_ready(tx_ready), .gnt(gnt), .rx_data(rx_data),
        .rx_valid(rx_valid), .spi_mosi_data(spi_mosi_data), .spi_start(spi_start),
        .spi_cs_n(spi_cs_n), .spi_miso_data(spi_miso_data), .spi_done(spi_done),
        .timeout(timeout)
    );

    typedef struct { logic [NR-1:0] who; logic [7:0] data; } exp_t;
    exp_t           sb[$];
    logic [7:0]     rx_log[$];
    logic [NR-1:0]  glog[$];

    int total, bad;
    int cyc, starts, rx_cnt, cs_rise, hi_run, to_cnt;
    bit master_en;
    bit prev_cs;
    logic [NR-1:0] prev_gnt;

    int         cnt[NR], blen[NR];
    logic [7:0] base[NR];
    bit         feed_en[NR], one_shot[NR];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Master model: answer each start with ~byte after DLY cycles
    initial begin
        logic [7:0] b;
        spi_done = 1'b0;
        spi_miso_data = '0;
        forever begin
            @(posedge clk); #1;
            if (spi_start && master_en) begin
                b = spi_mosi_data;
                repeat (DLY - 1) @(posedge clk);
                #1 spi_miso_data = ~b; spi_done = 1'b1;
                @(posedge clk);
                #1 spi_done = 1'b0;
            end
        end
    end

    // Requester byte feeders: bytes base+k, last on k=blen-1, wrapping
    initial begin
        tx_valid = '0; tx_last = '0; tx_data = '0;
        forever begin
            @(posedge clk); #1;
            for (int i = 0; i < NR; i++) begin
                if (tx_ready[i]) begin
                    cnt[i] = (cnt[i] + 1 >= blen[i]) ? 0 : cnt[i] + 1;
                    if (one_shot[i]) feed_en[i] = 1'b0;
                end
                tx_valid[i]       = feed_en[i];
                tx_data[8*i +: 8] = base[i] + 8'(cnt[i]);
                tx_last[i]        = (cnt[i] == blen[i] - 1);
            end
        end
    end

    // Monitor and scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (spi_start) begin
                check("start_cs_low", 32'(spi_cs_n), 0);
                starts++;
                if (master_en) sb.push_back('{gnt, ~spi_mosi_data});
            end
            if (rx_valid != '0) begin
                if (sb.size() == 0) check("rx_unexpected", 32'(rx_valid), 0);
                else begin
                    e = sb.pop_front();
                    check("rx_data", 32'(rx_data), 32'(e.data));
                    check("rx_valid_who", 32'(rx_valid), 32'(e.who));
                end
                rx_log.push_back(rx_data);
                rx_cnt++;
            end
            if (spi_cs_n) hi_run++;
            else begin
                if (hi_run > 0) check("cs_gap", 32'(hi_run >= CS_GAP), 1);
                hi_run = 0;
            end
            if (spi_cs_n && !prev_cs) cs_rise++;
            prev_cs = spi_cs_n;
            if (gnt != '0 && prev_gnt == '0) begin
                glog.push_back(gnt);
                check("gnt_onehot", 32'($onehot(gnt)), 1);
            end
            prev_gnt = gnt;
            if (timeout) to_cnt++;
        end
    end

    task automatic tick();
        @(negedge clk); #1;
    endtask

    task automatic feed(input int i, input logic [7:0] b, input int n, input bit os);
        base[i] = b; blen[i] = n; cnt[i] = 0; one_shot[i] = os; feed_en[i] = 1'b1;
    endtask

    task automatic stop_all();
        req = '0;
        for (int i = 0; i < NR; i++) feed_en[i] = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk) rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        #1;
    endtask

    task automatic wait_start(input string tag);
        int k = 0;
        while (!spi_start && k < 100) begin tick(); k++; end
        if (!spi_start) check(tag, 0, 1);
    endtask

    task automatic wait_gnt(input string tag);
        int k = 0;
        while (gnt == '0 && k < 100) begin tick(); k++; end
        if (gnt == '0) check(tag, 0, 1);
    endtask

    task automatic wait_cs_high(input string tag);
        int k = 0;
        while (!spi_cs_n && k < 200) begin tick(); k++; end
        if (!spi_cs_n) check(tag, 0, 1);
    endtask

    task automatic wait_rx(input int target, input string tag);
        int k = 0;
        while (rx_cnt < target && k < 300) begin tick(); k++; end
        if (rx_cnt < target) check(tag, 32'(rx_cnt), 32'(target));
    endtask

    initial begin
        int s0, r0, c0, g0, t0, k;
        total = 0; bad = 0; cyc = 0; starts = 0; rx_cnt = 0; cs_rise = 0;
        hi_run = 0; to_cnt = 0; master_en = 1'b1; prev_cs = 1'b1; prev_gnt = '0;
        for (int i = 0; i < NR; i++) begin
            cnt[i] = 0; blen[i] = 1; base[i] = '0; feed_en[i] = 1'b0; one_shot[i] = 1'b0;
        end
        req = '0;
        rst_n = 1'b0;
        repeat (2) tick();
        check("rst_gnt", 32'(gnt), 0);
        check("rst_cs_n", 32'(spi_cs_n), 1);
        check("rst_tx_ready", 32'(tx_ready), 0);
        check("rst_rx_valid", 32'(rx_valid), 0);
        check("rst_rx_data", 32'(rx_data), 0);
        check("rst_mosi", 32'(spi_mosi_data), 0);
        check("rst_start", 32'(spi_start), 0);
        check("rst_timeout", 32'(timeout), 0);
        @(negedge clk) rst_n = 1'b1;
        #1;

        // 3-byte burst from requester 0
        feed(0, 8'hA1, 3, 1'b0);
        s0 = starts; r0 = rx_cnt; c0 = cs_rise; rx_log.delete();
        @(posedge clk); #1 req = 2'b01;
        tick(); check("t1_gnt_early", 32'(gnt), 0);
        tick(); check("t1_gnt", 32'(gnt), 32'h1);
        check("t1_cs_low", 32'(spi_cs_n), 0);
        tick(); check("t1_ready_early", 32'(tx_ready), 0);
        tick(); check("t1_ready", 32'(tx_ready), 32'h1);
        check("t1_start", 32'(spi_start), 1);
        check("t1_mosi", 32'(spi_mosi_data), 32'hA1);
        wait_rx(r0 + 3, "t1_rx_wait");
        stop_all();
        check("t1_cs_end", 32'(spi_cs_n), 1);
        check("t1_starts", 32'(starts - s0), 3);
        check("t1_cs_rises", 32'(cs_rise - c0), 1);
        check("t1_rx0", 32'(rx_log[0]), 32'h5E);
        check("t1_rx1", 32'(rx_log[1]), 32'h5D);
        check("t1_rx2", 32'(rx_log[2]), 32'h5C);
        for (int j = 0; j < 2; j++) begin
            tick(); check("t1_cs_gap_hold", 32'(spi_cs_n), 1);
        end
        repeat (5) tick();

        // Both requesting, single-byte bursts: alternate from requester 0
        do_reset();
        g0 = glog.size(); r0 = rx_cnt;
        feed(0, 8'h10, 1, 1'b0);
        feed(1, 8'h20, 1, 1'b0);
        @(posedge clk); #1 req = 2'b11;
        k = 0;
        while (glog.size() < g0 + 4 && k < 400) begin tick(); k++; end
        check("t2_grants", 32'(glog.size() - g0), 4);
        wait_cs_high("t2_cs_wait");
        stop_all();
        check("t2_rx_count", 32'(rx_cnt - r0), 4);
        for (int j = 0; j < 4; j++)
            check("t2_order", 32'(glog[g0 + j]), 32'(1 << (j % 2)));
        repeat (5) tick();

        // Requester 1 abandons a 4-byte burst in LOAD after one byte
        feed(1, 8'h30, 4, 1'b1);
        s0 = starts; r0 = rx_cnt;
        @(posedge clk); #1 req = 2'b10;
        wait_gnt("t3_gnt_wait");
        check("t3_gnt1", 32'(gnt), 32'h2);
        feed(0, 8'h40, 1, 1'b0);
        req[0] = 1'b1;
        wait_rx(r0 + 1, "t3_rx_wait");
        check("t3_cs_held", 32'(spi_cs_n), 0);
        req[1] = 1'b0;
        tick();
        check("t3_cs_rise", 32'(spi_cs_n), 1);
        check("t3_gnt_drop", 32'(gnt), 0);
        check("t3_starts", 32'(starts - s0), 1);
        wait_gnt("t3_gnt0_wait");
        check("t3_gnt0", 32'(gnt), 32'h1);
        wait_cs_high("t3_cs_wait");
        stop_all();
        check("t3_rx_count", 32'(rx_cnt - r0), 2);
        repeat (5) tick();

        // req[0] drops while a byte is in flight
        feed(0, 8'h50, 4, 1'b0);
        s0 = starts; r0 = rx_cnt;
        @(posedge clk); #1 req = 2'b01;
        wait_start("t4_start_wait");
        stop_all();
        wait_rx(r0 + 1, "t4_rx_wait");
        check("t4_cs_after", 32'(spi_cs_n), 1);
        repeat (20) tick();
        check("t4_starts", 32'(starts - s0), 1);
        check("t4_rx_count", 32'(rx_cnt - r0), 1);

        // Asynchronous reset in the middle of a transfer
        feed(0, 8'h60, 4, 1'b0);
        @(posedge clk); #1 req = 2'b01;
        wait_start("t5_start_wait");
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t5_async_cs", 32'(spi_cs_n), 1);
        check("t5_async_gnt", 32'(gnt), 0);
        stop_all();
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (25) tick();
        feed(0, 8'h61, 1, 1'b0);
        feed(1, 8'h62, 1, 1'b0);
        @(posedge clk); #1 req = 2'b11;
        wait_gnt("t5_gnt_wait");
        check("t5_first_win", 32'(gnt), 32'h1);
        wait_cs_high("t5_cs_wait");
        stop_all();
        repeat (5) tick();

`ifdef SPI_ARB_TIMEOUT_EN
        // Master never answers: watchdog aborts the burst
        master_en = 1'b0;
        r0 = rx_cnt; k = to_cnt;
        feed(0, 8'h70, 1, 1'b0);
        @(posedge clk); #1 req = 2'b01;
        wait_start("t6_start_wait");
        t0 = cyc;
        s0 = 0;
        while (!timeout && s0 < 40) begin tick(); s0++; end
        check("t6_timeout_seen", 32'(timeout), 1);
        check("t6_latency", 32'(cyc - t0), TO);
        check("t6_cs", 32'(spi_cs_n), 1);
        check("t6_gnt", 32'(gnt), 0);
        stop_all();
        repeat (10) tick();
        check("t6_no_rx", 32'(rx_cnt - r0), 0);
        check("t6_pulses", 32'(to_cnt - k), 1);
        master_en = 1'b1;
        feed(0, 8'h71, 1, 1'b0);
        @(posedge clk); #1 req = 2'b01;
        wait_gnt("t6_regnt_wait");
        check("t6_regnt", 32'(gnt), 32'h1);
        wait_cs_high("t6_cs_wait");
        stop_all();
        repeat (5) tick();
`else
        check("no_timeout", 32'(to_cnt), 0);
`endif
        check("sb_empty", 32'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule
